// File: rtl/mux8_1_pkg.sv
// rtl/mux8_1_pkg.sv - shared constants for the registered 8-to-1 multiplexer
package mux8_1_pkg;
  localparam int NUM_INPUTS = 8;
  localparam int SEL_W      = 3;
  localparam int DATA_W     = 4;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux8_1_if.sv
// rtl/mux8_1_if.sv - data candidates, select and registered result of the mux
interface mux8_1_if
  import mux8_1_pkg::*;
#(
  parameter int WIDTH = DATA_W
) ();
  logic [WIDTH-1:0] datain_0;
  logic [WIDTH-1:0] datain_1;
  logic [WIDTH-1:0] datain_2;
  logic [WIDTH-1:0] datain_3;
  logic [WIDTH-1:0] datain_4;
  logic [WIDTH-1:0] datain_5;
  logic [WIDTH-1:0] datain_6;
  logic [WIDTH-1:0] datain_7;
  sel_t             select;
  logic [WIDTH-1:0] out;

  modport master (
    output datain_0, datain_1, datain_2, datain_3,
    output datain_4, datain_5, datain_6, datain_7,
    output select,
    input  out
  );

  modport slave (
    input  datain_0, datain_1, datain_2, datain_3,
    input  datain_4, datain_5, datain_6, datain_7,
    input  select,
    output out
  );
endinterface

// File: rtl/mux8_1_core.sv
// rtl/mux8_1_core.sv - purely combinational 8-way selection of WIDTH bits
module mux8_1_core
  import mux8_1_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  sel_t             select,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (select)
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      3'd4:    y = d4;
      3'd5:    y = d5;
      3'd6:    y = d6;
      3'd7:    y = d7;
      // only reachable with unknown select bits; propagate the unknown
      default: y = 'x;
    endcase
  end
endmodule

// File: rtl/mux8_1.sv
// rtl/mux8_1.sv - registered 8-to-1 multiplexer with synchronous reset
module mux8_1
  import mux8_1_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input logic     clk,
  input logic     rst,
  mux8_1_if.slave bus
);
  logic [WIDTH-1:0] sel_data;

  mux8_1_core #(.WIDTH(WIDTH)) u_core (
    .d0     (bus.datain_0),
    .d1     (bus.datain_1),
    .d2     (bus.datain_2),
    .d3     (bus.datain_3),
    .d4     (bus.datain_4),
    .d5     (bus.datain_5),
    .d6     (bus.datain_6),
    .d7     (bus.datain_7),
    .select (bus.select),
    .y      (sel_data)
  );

  // output comes only from this register, so it never glitches between edges
  always_ff @(posedge clk) begin
    if (rst) bus.out <= '0;
    else     bus.out <= sel_data;
  end
endmodule

// File: tb/tb_mux8_1.sv
// tb/tb_mux8_1.sv - directed vector bench for the registered 8-to-1 multiplexer
module tb_mux8_1;
  typedef struct {
    logic            rst;
    logic [2:0]      sel;
    logic [7:0][3:0] d;
    logic [3:0]      exp;
    string           name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];

  mux8_1_if #(.WIDTH(4)) bus ();
  mux8_1 #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic add_vec(input logic r, input logic [2:0] s, input logic [7:0][3:0] d,
                         input logic [3:0] e, input string nm);
    vec_t v;
    v.rst = r; v.sel = s; v.d = d; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [2:0] s, input logic [7:0][3:0] d);
    rst = r;
    bus.select = s;
    bus.datain_0 = d[0]; bus.datain_1 = d[1]; bus.datain_2 = d[2]; bus.datain_3 = d[3];
    bus.datain_4 = d[4]; bus.datain_5 = d[5]; bus.datain_6 = d[6]; bus.datain_7 = d[7];
  endtask

  task automatic check(input string nm, input logic [3:0] exp);
    n_vec++;
    if (bus.out !== exp) begin
      n_err++;
      $display("FAIL %s: out=%0d expected=%0d", nm, bus.out, exp);
    end
  endtask

  initial begin
    logic [7:0][3:0] base, mod3, noisy;
    logic [3:0]      held;
    logic [3:0]      tog_exp;

    base[0] = 4'd15; base[1] = 4'd12; base[2] = 4'd10; base[3] = 4'd9;
    base[4] = 4'd5;  base[5] = 4'd2;  base[6] = 4'd8;  base[7] = 4'd4;
    mod3 = base;
    mod3[3] = 4'd6;
    noisy = {4'd1, 4'd3, 4'd7, 4'd0, 4'd6, 4'd11, 4'd13, 4'd14};
    noisy[3] = 4'd6;

    add_vec(1'b1, 3'd5, base, 4'd0, "reset_edge1");
    add_vec(1'b1, 3'd5, base, 4'd0, "reset_edge2");
    add_vec(1'b0, 3'd5, base, 4'd2, "first_after_reset");
    add_vec(1'b0, 3'd0, base, 4'd15, "sweep_sel0");
    add_vec(1'b0, 3'd1, base, 4'd12, "sweep_sel1");
    add_vec(1'b0, 3'd2, base, 4'd10, "sweep_sel2");
    add_vec(1'b0, 3'd3, base, 4'd9,  "sweep_sel3");
    add_vec(1'b0, 3'd4, base, 4'd5,  "sweep_sel4");
    add_vec(1'b0, 3'd5, base, 4'd2,  "sweep_sel5");
    add_vec(1'b0, 3'd6, base, 4'd8,  "sweep_sel6");
    add_vec(1'b0, 3'd7, base, 4'd4,  "sweep_sel7");
    add_vec(1'b0, 3'd3, base, 4'd9,  "sel3_before_change");
    add_vec(1'b0, 3'd3, mod3, 4'd6,  "sel3_after_change");
    add_vec(1'b0, 3'd3, noisy, 4'd6, "sel3_others_change");
    add_vec(1'b0, 3'd7, base, 4'd4,  "sel7_steady");
    add_vec(1'b1, 3'd7, base, 4'd0,  "midstream_reset");
    add_vec(1'b0, 3'd7, base, 4'd4,  "after_midstream_reset");
    add_vec(1'b1, 3'd2, noisy, 4'd0, "reset_priority_noisy");
    add_vec(1'b0, 3'd0, {8{4'hF}}, 4'hF, "all_ones_width");

    drive(1'b1, 3'd5, base);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].sel, vecs[i].d);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].exp);
    end

    // back-to-back 0/7 toggling: exact 1-cycle latency and stable between edges
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b0, (i % 2 == 0) ? 3'd0 : 3'd7, base);
      tog_exp = (i % 2 == 0) ? 4'd15 : 4'd4;
      #1;
      check("toggle_pre_edge_hold", (i == 0) ? 4'hF : ((i % 2 == 0) ? 4'd4 : 4'd15));
      @(posedge clk);
      #1;
      check("toggle_after_edge", tog_exp);
      held = bus.out;
      #3;
      check("toggle_stable_mid", tog_exp);
      if (bus.out !== held) begin
        n_err++;
        $display("FAIL toggle_glitch: out=%0d expected=%0d", bus.out, held);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
